// File: rtl/alu_controller_pkg.sv
// Shared 8051 ALU definitions: opcode constants, controller state encoding,
// the latched request payload and small opcode-decode helpers.
package alu_controller_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned OP_W   = 4;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned FLAG_W = 3;

    // ALU opcodes; codes above ALU_SWAP are unsupported.
    localparam logic [OP_W-1:0] ALU_ADD  = 4'd0;
    localparam logic [OP_W-1:0] ALU_ADDC = 4'd1;
    localparam logic [OP_W-1:0] ALU_SUBB = 4'd2;
    localparam logic [OP_W-1:0] ALU_INC  = 4'd3;
    localparam logic [OP_W-1:0] ALU_DEC  = 4'd4;
    localparam logic [OP_W-1:0] ALU_MUL  = 4'd5;
    localparam logic [OP_W-1:0] ALU_DIV  = 4'd6;
    localparam logic [OP_W-1:0] ALU_DA   = 4'd7;
    localparam logic [OP_W-1:0] ALU_RR   = 4'd8;
    localparam logic [OP_W-1:0] ALU_RL   = 4'd9;
    localparam logic [OP_W-1:0] ALU_RRC  = 4'd10;
    localparam logic [OP_W-1:0] ALU_RLC  = 4'd11;
    localparam logic [OP_W-1:0] ALU_CPL  = 4'd12;
    localparam logic [OP_W-1:0] ALU_SWAP = 4'd13;

    // Controller state encoding.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_CAPTURE = 2'd3
    } state_e;

    // Request captured on the accept edge.
    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic              cy;
        logic              ac;
    } alu_req_t;

    function automatic logic is_muldiv(input logic [OP_W-1:0] op);
        return (op == ALU_MUL) || (op == ALU_DIV);
    endfunction

    function automatic logic is_supported(input logic [OP_W-1:0] op);
        return op <= ALU_SWAP;
    endfunction

    // PSW write enables {cy, ac, ov} per opcode.
    function automatic logic [FLAG_W-1:0] flag_we_for(input logic [OP_W-1:0] op);
        case (op)
            ALU_ADD, ALU_ADDC, ALU_SUBB:                         return 3'b111;
            ALU_MUL, ALU_DIV:                                    return 3'b101;
            ALU_RRC, ALU_RLC, ALU_DA:                            return 3'b100;
            default:                                             return 3'b000;
        endcase
    endfunction

    // Decimal-adjust carry, owned by the controller rather than alu_core.
    function automatic logic da_carry(input logic [DATA_W-1:0] a, input logic cy);
        return cy | (a[7:4] > 4'd9) | ((a[7:4] == 4'd9) & (a[3:0] > 4'd9));
    endfunction

endpackage

// File: rtl/alu_controller_if.sv
// Controller <-> alu_core bus.
//   master (controller): drives alu_opcode, alu_op_1, alu_op_2, alu_cy, alu_ac;
//                        receives alu_res_1, alu_res_2, alu_cy_out, alu_ac_out, alu_ov_out.
//   slave  (alu_core):   the mirror image.
interface alu_controller_if;
    import alu_controller_pkg::*;

    logic [OP_W-1:0]   alu_opcode;
    logic [DATA_W-1:0] alu_op_1;
    logic [DATA_W-1:0] alu_op_2;
    logic              alu_cy;
    logic              alu_ac;
    logic [DATA_W-1:0] alu_res_1;
    logic [DATA_W-1:0] alu_res_2;
    logic              alu_cy_out;
    logic              alu_ac_out;
    logic              alu_ov_out;

    modport master (
        output alu_opcode, alu_op_1, alu_op_2, alu_cy, alu_ac,
        input  alu_res_1, alu_res_2, alu_cy_out, alu_ac_out, alu_ov_out
    );

    modport slave (
        input  alu_opcode, alu_op_1, alu_op_2, alu_cy, alu_ac,
        output alu_res_1, alu_res_2, alu_cy_out, alu_ac_out, alu_ov_out
    );

endinterface

// File: rtl/alu_controller.sv
// ALU sequencing controller: accepts one request at a time, presents the
// latched operands to a 1-cycle registered alu_core, waits MULDIV_CYCLES for
// MUL/DIV, then captures results and pulses done (and err for bad opcodes).
// Ports:
//   clock, reset        system clock, async active-low reset
//   start, op, src_a, src_b, psw_cy, psw_ac   request (sampled only when idle)
//   alu                 alu_core bus (master side)
//   busy, done, err     status; done/err are single-cycle pulses
//   result_lo/hi, cy_out, ac_out, ov_out      registered results
//   flag_we             {cy,ac,ov} PSW write enables, non-zero only with done
module alu_controller
    import alu_controller_pkg::*;
#(
    parameter int unsigned MULDIV_CYCLES = 4  // legal 2..15
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic [OP_W-1:0]     op,
    input  logic [DATA_W-1:0]   src_a,
    input  logic [DATA_W-1:0]   src_b,
    input  logic                psw_cy,
    input  logic                psw_ac,
    alu_controller_if.master    alu,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [DATA_W-1:0]   result_lo,
    output logic [DATA_W-1:0]   result_hi,
    output logic                cy_out,
    output logic                ac_out,
    output logic                ov_out,
    output logic [FLAG_W-1:0]   flag_we
);

    // WAIT occupancy is MULDIV_CYCLES-2 cycles; the counter counts down to 0.
    localparam int unsigned WAIT_LOAD = (MULDIV_CYCLES > 3) ? (MULDIV_CYCLES - 3) : 0;
    localparam bit          USE_WAIT  = (MULDIV_CYCLES > 2);

    state_e             state;
    alu_req_t           req;
    logic [CNT_W-1:0]   wait_cnt;

    logic [DATA_W-1:0]  cap_lo_c;
    logic [DATA_W-1:0]  cap_hi_c;
    logic               cap_cy_c;
    logic               cap_ac_c;
    logic               cap_ov_c;
    logic               div_zero_c;

    // alu_core sees only the latched request, so it is stable for the whole op.
    assign alu.alu_opcode = req.op;
    assign alu.alu_op_1   = req.a;
    assign alu.alu_op_2   = req.b;
    assign alu.alu_cy     = req.cy;
    assign alu.alu_ac     = req.ac;

    // Result selection applied at the capture edge.
    always_comb begin
        div_zero_c = (req.op == ALU_DIV) && (req.b == '0);
        cap_lo_c   = alu.alu_res_1;
        cap_hi_c   = req.b;
        cap_cy_c   = alu.alu_cy_out;
        cap_ac_c   = alu.alu_ac_out;
        cap_ov_c   = alu.alu_ov_out;
        if (is_muldiv(req.op)) begin
            cap_hi_c = alu.alu_res_2;
        end
        if (req.op == ALU_DA) begin
            cap_cy_c = da_carry(req.a, req.cy);
        end
        // Divide by zero ignores whatever alu_core produced.
        if (div_zero_c) begin
            cap_lo_c = '0;
            cap_hi_c = '0;
            cap_cy_c = 1'b0;
            cap_ac_c = 1'b0;
            cap_ov_c = 1'b1;
        end
        if (!is_supported(req.op)) begin
            cap_lo_c = req.a;
            cap_cy_c = 1'b0;
            cap_ac_c = 1'b0;
            cap_ov_c = 1'b0;
        end
    end

    // Sequencer with registered status and results.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            req       <= '0;
            wait_cnt  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            flag_we   <= '0;
            result_lo <= '0;
            result_hi <= '0;
            cy_out    <= 1'b0;
            ac_out    <= 1'b0;
            ov_out    <= 1'b0;
        end else begin
            done    <= 1'b0;
            err     <= 1'b0;
            flag_we <= '0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        req   <= alu_req_t'{op: op, a: src_a, b: src_b, cy: psw_cy, ac: psw_ac};
                        busy  <= 1'b1;
                        state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (is_muldiv(req.op) && USE_WAIT) begin
                        wait_cnt <= CNT_W'(WAIT_LOAD);
                        state    <= ST_WAIT;
                    end else begin
                        state <= ST_CAPTURE;
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt == '0) begin
                        state <= ST_CAPTURE;
                    end else begin
                        wait_cnt <= wait_cnt - CNT_W'(1);
                    end
                end
                ST_CAPTURE: begin
                    result_lo <= cap_lo_c;
                    result_hi <= cap_hi_c;
                    cy_out    <= cap_cy_c;
                    ac_out    <= cap_ac_c;
                    ov_out    <= cap_ov_c;
                    flag_we   <= flag_we_for(req.op);
                    err       <= !is_supported(req.op);
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_controller.sv
// Bench for alu_controller: behavioural alu_core, randomized requests,
// scoreboard queue of expected completions checked by a negedge monitor.
module tb_alu_controller;
    import alu_controller_pkg::*;

    localparam int MD = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [3:0] op = '0;
    logic [7:0] src_a = '0, src_b = '0;
    logic       psw_cy = 1'b0, psw_ac = 1'b0;
    logic       busy, done, err, cy_out, ac_out, ov_out;
    logic [7:0] result_lo, result_hi;
    logic [2:0] flag_we;

    alu_controller_if aif();

    alu_controller #(.MULDIV_CYCLES(MD)) dut (
        .clock(clock), .reset(reset), .start(start), .op(op),
        .src_a(src_a), .src_b(src_b), .psw_cy(psw_cy), .psw_ac(psw_ac),
        .alu(aif), .busy(busy), .done(done), .err(err),
        .result_lo(result_lo), .result_hi(result_hi),
        .cy_out(cy_out), .ac_out(ac_out), .ov_out(ov_out), .flag_we(flag_we)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct packed {
        logic [7:0] res1;
        logic [7:0] res2;
        logic       cy;
        logic       ac;
        logic       ov;
    } core_t;

    typedef struct {
        logic [7:0] lo;
        logic [7:0] hi;
        logic       cy, ac, ov;
        logic [2:0] we;
        logic       err;
        int         acc_edge;
        int         done_edge;
    } exp_t;

    exp_t q[$];
    int   last_done = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    function automatic int sgn(input int v);
        return (v > 127) ? v - 256 : v;
    endfunction

    // Instruction-set semantics of alu_core in plain integer arithmetic.
    function automatic core_t core_calc(input logic [3:0] o, input logic [7:0] a, b,
                                        input logic c, h);
        core_t r;
        int ia, ib, ic, v;
        ia = int'(a); ib = int'(b); ic = int'(c);
        r = '{res1: 8'h00, res2: 8'h00, cy: c, ac: h, ov: 1'b0};
        case (o)
            ALU_ADD, ALU_ADDC: begin
                if (o == ALU_ADD) ic = 0;
                v = ia + ib + ic;
                r.res1 = 8'(v);
                r.cy = (v > 255);
                r.ac = ((ia % 16) + (ib % 16) + ic) > 15;
                r.ov = (sgn(ia) + sgn(ib) + ic > 127) || (sgn(ia) + sgn(ib) + ic < -128);
            end
            ALU_SUBB: begin
                v = ia - ib - ic;
                r.res1 = 8'(v + 256);
                r.cy = (v < 0);
                r.ac = ((ia % 16) - (ib % 16) - ic) < 0;
                r.ov = (sgn(ia) - sgn(ib) - ic > 127) || (sgn(ia) - sgn(ib) - ic < -128);
            end
            ALU_INC:  r.res1 = 8'(ia + 1);
            ALU_DEC:  r.res1 = 8'(ia + 255);
            ALU_MUL: begin
                v = ia * ib;
                r.res1 = 8'(v % 256);
                r.res2 = 8'(v / 256);
                r.cy = 1'b0;
                r.ov = (v > 255);
            end
            ALU_DIV: begin
                if (ib != 0) begin
                    r.res1 = 8'(ia / ib);
                    r.res2 = 8'(ia % ib);
                    r.cy = 1'b0;
                end else begin
                    // Garbage the controller must not use.
                    r.res1 = 8'hEE; r.res2 = 8'hDD; r.cy = 1'b1;
                end
            end
            ALU_DA: begin
                v = ia;
                if ((ia % 16) > 9 || h) v = v + 6;
                if ((v / 16) > 9 || c) v = v + 96;
                r.res1 = 8'(v % 256);
                r.cy = 1'b0;  // this core leaves the DA carry to the controller
            end
            ALU_RR:   r.res1 = 8'((ia % 2) * 128 + ia / 2);
            ALU_RL:   r.res1 = 8'(((ia * 2) % 256) + ia / 128);
            ALU_RRC: begin r.res1 = 8'(ic * 128 + ia / 2);        r.cy = (ia % 2) == 1; end
            ALU_RLC: begin r.res1 = 8'(((ia * 2) % 256) + ic);    r.cy = (ia / 128) == 1; end
            ALU_CPL:  r.res1 = 8'(255 - ia);
            ALU_SWAP: r.res1 = 8'((ia % 16) * 16 + ia / 16);
            default: r = '{res1: 8'h5A, res2: 8'hA5, cy: 1'b1, ac: 1'b1, ov: 1'b1};
        endcase
        return r;
    endfunction

    function automatic logic [2:0] we_of(input logic [3:0] o);
        case (o)
            ALU_ADD, ALU_ADDC, ALU_SUBB: return 3'b111;
            ALU_MUL, ALU_DIV:            return 3'b101;
            ALU_RRC, ALU_RLC, ALU_DA:    return 3'b100;
            default:                     return 3'b000;
        endcase
    endfunction

    // Expected controller completion for one request.
    function automatic exp_t expect_of(input logic [3:0] o, input logic [7:0] a, b,
                                       input logic c, h);
        exp_t  e;
        core_t r;
        r = core_calc(o, a, b, c, h);
        e.lo = r.res1;
        e.hi = (o == ALU_MUL || o == ALU_DIV) ? r.res2 : b;
        e.cy = r.cy; e.ac = r.ac; e.ov = r.ov;
        e.we = we_of(o);
        e.err = 1'b0;
        if (o == ALU_DA) e.cy = c || (a / 16 > 9) || (a / 16 == 9 && a % 16 > 9);
        if (o == ALU_DIV && b == 8'h00) begin
            e.lo = 8'h00; e.hi = 8'h00; e.cy = 1'b0; e.ac = 1'b0; e.ov = 1'b1;
        end
        if (o > 4'd13) begin
            e.lo = a; e.hi = b; e.cy = 1'b0; e.ac = 1'b0; e.ov = 1'b0;
            e.we = 3'b000; e.err = 1'b1;
        end
        e.acc_edge = 0;
        e.done_edge = (o == ALU_MUL || o == ALU_DIV) ? MD : 2;
        return e;
    endfunction

    // Registered alu_core model.
    always @(posedge clock) begin : core_model
        core_t r;
        r = core_calc(aif.alu_opcode, aif.alu_op_1, aif.alu_op_2, aif.alu_cy, aif.alu_ac);
        aif.alu_res_1  <= r.res1;
        aif.alu_res_2  <= r.res2;
        aif.alu_cy_out <= r.cy;
        aif.alu_ac_out <= r.ac;
        aif.alu_ov_out <= r.ov;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Issue one request; while the model says busy, wiggle start/op as noise.
    task automatic issue(input logic [3:0] o, input logic [7:0] a, b, input logic c, h,
                         input bit noise);
        exp_t e;
        while (cyc + 1 <= last_done) begin
            if (noise) begin
                start = 1'($urandom); op = 4'($urandom);
                src_a = 8'($urandom); src_b = 8'($urandom);
            end
            tick();
        end
        op = o; src_a = a; src_b = b; psw_cy = c; psw_ac = h; start = 1'b1;
        e = expect_of(o, a, b, c, h);
        e.acc_edge = cyc + 1;
        e.done_edge = e.acc_edge + e.done_edge;
        last_done = e.done_edge;
        q.push_back(e);
        tick();
        start = 1'b0;
        op = 4'($urandom); src_a = 8'($urandom); src_b = 8'($urandom);
        psw_cy = 1'($urandom); psw_ac = 1'($urandom);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_err"}, 32'(err), 0);
        check({tag, "_flag_we"}, 32'(flag_we), 0);
        check({tag, "_results"}, {16'h0, result_hi, result_lo}, 0);
        check({tag, "_flags"}, {29'h0, cy_out, ac_out, ov_out}, 0);
        check({tag, "_alu_req"}, {9'h0, aif.alu_opcode, aif.alu_op_1, aif.alu_op_2,
                                  aif.alu_cy, aif.alu_ac}, 0);
    endtask

    // Monitor: busy against the model every cycle, completions against the queue.
    always @(negedge clock) begin : monitor
        exp_t e;
        logic exp_busy;
        if (reset) begin
            exp_busy = (q.size() > 0) && (cyc >= q[0].acc_edge) && (cyc < q[0].done_edge);
            check("busy", 32'(busy), 32'(exp_busy));
            if (done) begin
                if (q.size() == 0) begin
                    check("unexpected_done", 32'(done), 0);
                end else begin
                    e = q.pop_front();
                    check("done_edge", 32'(cyc), 32'(e.done_edge));
                    check("result_lo", 32'(result_lo), 32'(e.lo));
                    check("result_hi", 32'(result_hi), 32'(e.hi));
                    check("cy_ac_ov", {29'h0, cy_out, ac_out, ov_out}, {29'h0, e.cy, e.ac, e.ov});
                    check("flag_we", 32'(flag_we), 32'(e.we));
                    check("err", 32'(err), 32'(e.err));
                end
            end else begin
                check("flag_we_idle", 32'(flag_we), 0);
                check("err_idle", 32'(err), 0);
                if (q.size() > 0 && cyc >= q[0].done_edge) begin
                    check("missing_done", 32'(done), 1);
                    void'(q.pop_front());
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [3:0] o;
        logic [7:0] b;
        repeat (3) @(posedge clock);
        #1;
        check_all_zero("reset");
        reset = 1'b1;

        // Directed cases.
        issue(ALU_ADD,  8'h7F, 8'h01, 1'b0, 1'b0, 0);
        issue(ALU_MUL,  8'h50, 8'hA0, 1'b0, 1'b0, 0);
        issue(ALU_DIV,  8'h25, 8'h00, 1'b1, 1'b1, 0);
        issue(ALU_RLC,  8'h81, 8'h33, 1'b0, 1'b0, 0);
        issue(ALU_DA,   8'h9A, 8'h00, 1'b0, 1'b0, 0);
        issue(ALU_DA,   8'h45, 8'h00, 1'b1, 1'b0, 0);
        issue(ALU_DIV,  8'hC8, 8'h07, 1'b1, 1'b0, 0);
        issue(4'hE,     8'h3C, 8'h12, 1'b1, 1'b1, 0);

        // Back-to-back: INC held through busy is ignored, next start on done cycle.
        issue(ALU_ADD,  8'h10, 8'h20, 1'b0, 1'b0, 0);
        op = ALU_INC; src_a = 8'h55; start = 1'b1;
        while (cyc + 1 <= last_done) tick();
        issue(ALU_SUBB, 8'h10, 8'h20, 1'b1, 1'b0, 0);
        issue(ALU_SWAP, 8'hA5, 8'h01, 1'b0, 1'b0, 0);

        // Reset during WAIT of a MUL.
        issue(ALU_MUL,  8'hFF, 8'hFF, 1'b0, 1'b0, 0);
        tick();
        tick();
        #2;
        reset = 1'b0;
        q.delete();
        last_done = 0;
        #1;
        check_all_zero("midop_reset");
        start = 1'b1; op = ALU_ADD;
        tick();
        tick();
        check_all_zero("held_reset");
        reset = 1'b1;
        issue(ALU_ADD,  8'h01, 8'h02, 1'b1, 1'b0, 0);

        // Randomized traffic with noise starts while busy.
        for (int i = 0; i < 300; i++) begin
            o = 4'($urandom_range(0, 15));
            b = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
            issue(o, 8'($urandom), b, 1'($urandom), 1'($urandom), 1);
            repeat ($urandom_range(0, 2)) tick();
        end

        for (int i = 0; i < 40 && q.size() > 0; i++) tick();
        check("drain_empty", 32'(q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_controller.md
ALU_CONTROLLER -- requirements
Module: alu_controller

Interface
REQ-001 SHALL have parameter MULDIV_CYCLES, default 4, the accept-to-done latency in clocks for MUL/DIV (legal 2..15).
REQ-002 SHALL have port clock  input  1  single system clock; all state updates on posedge clock.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-004 SHALL have port start  input  1  request strobe; sampled only when busy=0.
REQ-005 SHALL have port op  input  4  ALU opcode, encoded per the shared ALU_* defines.
REQ-006 SHALL have ports src_a, src_b  input  8 each  operands (A, B).
REQ-007 SHALL have ports psw_cy, psw_ac  input  1 each  current PSW carry and aux-carry.
REQ-008 SHALL have ports alu_opcode (4), alu_op_1 (8), alu_op_2 (8), alu_cy (1), alu_ac (1)  output  drive to alu_core.
REQ-009 SHALL have ports alu_res_1, alu_res_2 (8 each), alu_cy_out, alu_ac_out, alu_ov_out (1 each)  input  from alu_core.
REQ-010 SHALL have ports busy (1), done (1), err (1)  output  status; done and err are 1-cycle pulses.
REQ-011 SHALL have ports result_lo, result_hi  output  8 each  registered result (A, B).
REQ-012 SHALL have ports cy_out, ac_out, ov_out (1 each) and flag_we  output  3  {cy,ac,ov} write enables to PSW.

Function
REQ-013 SHALL implement FSM IDLE -> ISSUE -> (WAIT)* -> CAPTURE -> IDLE.
REQ-014 SHALL, in IDLE with start=1, latch op, src_a, src_b, psw_cy and psw_ac, and set busy=1 on that same edge (accept edge E0).
REQ-015 SHALL ignore start while busy=1; no queuing.
REQ-016 SHALL drive alu_* outputs only from latched registers; the values hold stable from ISSUE through CAPTURE and keep their last value in IDLE.
REQ-017 SHALL treat alu_core as 1-cycle registered: results are sampled at the edge after ISSUE.
REQ-018 SHALL pulse done on the cycle at E0+2 for all ops except MUL/DIV, which pulse at E0+MULDIV_CYCLES using a 4-bit WAIT counter.
REQ-019 SHALL clear busy on the same edge that raises done; start may be accepted on the cycle done is high.
REQ-020 SHALL set flag_we: ADD/ADDC/SUBB=3'b111; MUL/DIV=3'b101; RRC/RLC/DA=3'b100; INC/DEC/RR/RL/CPL/SWAP=3'b000. flag_we is valid only while done=1 and is 0 otherwise.
REQ-021 SHALL set result_hi=alu_res_2 for MUL/DIV, and result_hi=latched src_b for all other ops.
REQ-022 SHALL handle DIV with src_b=0 as follows: do not sample alu results; result_lo=result_hi=8'h00, cy_out=0, ov_out=1; latency unchanged.
REQ-023 SHALL compute DA cy_out = latched psw_cy OR (src_a[7:4]>9) OR (src_a[7:4]==9 AND src_a[3:0]>9).
REQ-024 SHALL complete an unsupported op code with result_lo=src_a, flag_we=0, and err=1 coincident with done.

Reset
REQ-025 SHALL, on reset=0 at any time including mid-operation, go to IDLE immediately and clear busy, done, err, flag_we, result_lo, result_hi, cy_out, ac_out, ov_out, the WAIT counter and all alu_* outputs to 0.
REQ-026 SHALL accept no start while reset=0; the first accept can occur at the first posedge after deassertion.

Structure
REQ-027 SHALL take ALU_* opcode constants and the state encodings (2-bit IDLE/ISSUE/WAIT/CAPTURE) from the shared 8051 define file.
REQ-028 SHALL instantiate no sub-module; alu_core is connected by the parent datapath.
REQ-029 SHALL fit in 120-400 lines of RTL.

Verification
REQ-030 SHALL verify ADD: A=8'h7F, B=8'h01, cy=0 -> done at E0+2, result_lo=8'h80, cy=0, ac=1, ov=1, flag_we=3'b111.
REQ-031 SHALL verify MUL: A=8'h50, B=8'hA0 -> done at E0+4, result_hi:result_lo=16'h3200, cy=0, ov=1, flag_we=3'b101.
REQ-032 SHALL verify DIV by zero: A=8'h25, B=8'h00 -> done at E0+4, results 8'h00, ov=1, cy=0.
REQ-033 SHALL verify back-to-back ops: an INC is held while busy and ignored, and a second start on the done cycle is accepted, with done at +2.
REQ-034 SHALL verify reset=0 asserted during WAIT of a MUL -> all outputs 0 immediately, state IDLE, no done pulse.
REQ-035 SHALL verify RLC: A=8'h81, cy=0 -> result_lo=8'h02, cy_out=1, flag_we=3'b100.
